irq_arbiter: RTL and testbench

Machine-level external interrupt arbiter sitting between the SoC interrupt sources and the trap unit. It synchronizes up to `NUM_SOURCES` asynchronous lines and latches them as pending in per-source gateways (level or edge mode). It arbitrates among pending, enabled, not-in-service sources by fixed priority and drives a single registered `o_meip` into the trap unit's `meip` input. Software services interrupts through a claim/complete register handshake over a simple MMIO port.

---
 rtl/irq_arbiter.sv | 132 +++++++++++++
 tb/tb_irq_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// irq_arbiter: synchronizes external interrupt lines into per-source level/edge
// gateways, selects the lowest-ID eligible source and raises a registered meip.
// Software claims and completes interrupts through a small MMIO register port.
module irq_arbiter #(
    parameter int unsigned NUM_SOURCES = 8,
    parameter int unsigned XLEN        = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_SOURCES-1:0] i_irq_sources,
    input  logic                   i_reg_rd_en,
    input  logic                   i_reg_wr_en,
    input  logic [1:0]             i_reg_addr,
    input  logic [XLEN-1:0]        i_reg_wdata,
    output logic [XLEN-1:0]        o_reg_rdata,
    output logic                   o_meip
);

    typedef enum logic [1:0] {
        REG_PENDING   = 2'd0,
        REG_ENABLE    = 2'd1,
        REG_CLAIM     = 2'd2,
        REG_EDGE_MODE = 2'd3
    } reg_addr_t;

    reg_addr_t addr;
    assign addr = reg_addr_t'(i_reg_addr);

    logic [NUM_SOURCES-1:0] sync1, sync2, sync_prev;
    logic [NUM_SOURCES-1:0] pending, in_service, enable, edge_mode;
    logic [NUM_SOURCES-1:0] pending_next, in_service_next, enable_next, edge_mode_next;
    logic [NUM_SOURCES-1:0] eligible, winner_mask, claim_mask, complete_mask, rise;
    logic [XLEN-1:0]        winner_id, rdata_next;
    logic                   found, claim;

    // Two-flop synchronizer plus a delayed copy of sync2 for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
        end else begin
            sync1     <= i_irq_sources;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // Fixed-priority arbitration: lowest index among eligible sources wins.
    always_comb begin
        eligible    = pending & enable & ~in_service;
        winner_mask = '0;
        winner_id   = '0;
        found       = 1'b0;
        for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
            if (eligible[i] && !found) begin
                found          = 1'b1;
                winner_mask[i] = 1'b1;
                winner_id      = XLEN'(i + 1);
            end
        end
    end

    // Gateway and register next-state; claim uses pre-edge enable/in_service.
    always_comb begin
        claim         = i_reg_rd_en && (addr == REG_CLAIM);
        claim_mask    = claim ? winner_mask : '0;
        complete_mask = '0;
        if (i_reg_wr_en && (addr == REG_CLAIM)) begin
            for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
                if (i_reg_wdata == XLEN'(i + 1)) begin
                    complete_mask[i] = in_service[i];
                end
            end
        end
        rise         = sync2 & ~sync_prev;
        pending_next = pending;
        for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
            // Edge mode: a new rising edge re-arms pending even while being claimed.
            if (edge_mode[i]) begin
                pending_next[i] = (pending[i] & ~claim_mask[i]) | rise[i];
            end else begin
                pending_next[i] = sync2[i] & ~in_service[i] & ~claim_mask[i];
            end
        end
        // Claim set is applied after complete clear so it wins on the same source.
        in_service_next = (in_service & ~complete_mask) | claim_mask;
        enable_next     = enable;
        edge_mode_next  = edge_mode;
        if (i_reg_wr_en && (addr == REG_ENABLE)) begin
            enable_next = i_reg_wdata[NUM_SOURCES-1:0];
        end
        if (i_reg_wr_en && (addr == REG_EDGE_MODE)) begin
            edge_mode_next = i_reg_wdata[NUM_SOURCES-1:0];
        end
    end

    // Read data mux; the register holds its value between reads.
    always_comb begin
        rdata_next = o_reg_rdata;
        if (i_reg_rd_en) begin
            rdata_next = '0;
            case (addr)
                REG_PENDING:   rdata_next[NUM_SOURCES-1:0] = pending;
                REG_ENABLE:    rdata_next[NUM_SOURCES-1:0] = enable;
                REG_CLAIM:     rdata_next                  = winner_id;
                REG_EDGE_MODE: rdata_next[NUM_SOURCES-1:0] = edge_mode;
                default:       rdata_next                  = '0;
            endcase
        end
    end

    // Architectural state, read data and meip (meip lags state by one edge).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending     <= '0;
            in_service  <= '0;
            enable      <= '0;
            edge_mode   <= '0;
            o_reg_rdata <= '0;
            o_meip      <= 1'b0;
        end else begin
            pending     <= pending_next;
            in_service  <= in_service_next;
            enable      <= enable_next;
            edge_mode   <= edge_mode_next;
            o_reg_rdata <= rdata_next;
            o_meip      <= |eligible;
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed scenarios followed by random traffic, all checked
// against a per-source behavioural model of the arbiter kept in this file.
module tb_irq_arbiter;

    localparam int NS = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NS-1:0] irq = '0;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [1:0]    addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          meip;

    int checks = 0;
    int errors = 0;

    irq_arbiter #(.NUM_SOURCES(NS), .XLEN(32)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_irq_sources (irq),
        .i_reg_rd_en   (rd_en),
        .i_reg_wr_en   (wr_en),
        .i_reg_addr    (addr),
        .i_reg_wdata   (wdata),
        .o_reg_rdata   (rdata),
        .o_meip        (meip)
    );

    always #5 clk = ~clk;

    // Reference model: per-source flags indexed by source, and the recent
    // history of sampled lines ([0] newest, [1] synchronized, [2] one older).
    bit          m_pend[NS], m_insvc[NS], m_en[NS], m_edge[NS];
    bit [NS-1:0] m_hist[3];
    bit          m_meip;
    logic [31:0] m_rdata;

    function automatic logic [31:0] pack(input bit v[NS]);
        logic [31:0] r = '0;
        for (int i = 0; i < NS; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic int m_winner();
        int w = 0;
        for (int id = NS; id >= 1; id--)
            if (m_pend[id-1] && m_en[id-1] && !m_insvc[id-1]) w = id;
        return w;
    endfunction

    task automatic model_step();
        int  win, claimed, completed;
        bit  line, rose;
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_pend[i] = 0; m_insvc[i] = 0; m_en[i] = 0; m_edge[i] = 0;
            end
            for (int k = 0; k < 3; k++) m_hist[k] = '0;
            m_meip  = 0;
            m_rdata = '0;
            return;
        end
        win       = m_winner();
        claimed   = (rd_en && addr == 2) ? win : 0;
        completed = 0;
        if (wr_en && addr == 2 && wdata >= 1 && wdata <= NS)
            if (m_insvc[wdata-1]) completed = int'(wdata);
        if (rd_en) begin
            case (addr)
                2'd0: m_rdata = pack(m_pend);
                2'd1: m_rdata = pack(m_en);
                2'd2: m_rdata = 32'(win);
                default: m_rdata = pack(m_edge);
            endcase
        end
        m_meip = (win != 0);
        for (int i = 0; i < NS; i++) begin
            line = m_hist[1][i];
            rose = line && !m_hist[2][i];
            if (m_edge[i]) m_pend[i] = (m_pend[i] && claimed != i + 1) || rose;
            else           m_pend[i] = line && !m_insvc[i] && claimed != i + 1;
            m_insvc[i] = (m_insvc[i] && completed != i + 1) || claimed == i + 1;
        end
        if (wr_en && addr == 1) for (int i = 0; i < NS; i++) m_en[i] = wdata[i];
        if (wr_en && addr == 3) for (int i = 0; i < NS; i++) m_edge[i] = wdata[i];
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = irq;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("meip_model", {31'b0, meip}, {31'b0, m_meip});
        check("rdata_model", rdata, m_rdata);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        rd_en = 1'b1; addr = a;
        tick();
        rd_en = 1'b0;
        d = rdata;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic pulse(input int src);
        irq[src] = 1'b1;
        idle(2);
        irq[src] = 1'b0;
        idle(2);
    endtask

    initial begin
        logic [31:0] d;
        int          first;

        // Reset state and basic level-mode latency on source 0.
        do_reset();
        check("reset_meip", {31'b0, meip}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        do_write(2'd1, 32'h01);
        irq[0] = 1'b1;
        first = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (meip === 1'b1 && first == 0) first = k;
        end
        check("meip_latency", 32'(first), 32'd4);
        do_read(2'd2, d);
        check("claim_src0", d, 32'd1);
        check("meip_claim_edge", {31'b0, meip}, 32'd1);
        tick();
        check("meip_after_claim", {31'b0, meip}, 32'd0);
        do_write(2'd2, 32'd1);
        check("meip_complete_t", {31'b0, meip}, 32'd0);
        tick();
        check("meip_complete_t1", {31'b0, meip}, 32'd0);
        tick();
        check("meip_complete_t2", {31'b0, meip}, 32'd1);
        irq = '0;

        // Priority between sources 2 and 5, then re-pending after complete.
        do_reset();
        irq = 8'h24;
        do_write(2'd1, 32'hFF);
        idle(4);
        do_read(2'd2, d); check("prio_claim1", d, 32'd3);
        do_read(2'd2, d); check("prio_claim2", d, 32'd6);
        do_read(2'd2, d); check("prio_claim3", d, 32'd0);
        do_write(2'd2, 32'd3);
        do_write(2'd2, 32'd6);
        idle(3);
        do_read(2'd0, d); check("prio_pending", d, 32'h24);
        irq = '0;

        // Edge mode on source 1: merged pulses, pulse while in service.
        do_reset();
        do_write(2'd1, 32'hFF);
        do_write(2'd3, 32'h02);
        pulse(1); pulse(1); pulse(1);
        idle(3);
        do_read(2'd2, d); check("edge_claim", d, 32'd2);
        do_read(2'd0, d); check("edge_pend_clr", d, 32'h00);
        pulse(1);
        idle(3);
        do_read(2'd0, d); check("edge_pend_insvc", d, 32'h02);
        do_read(2'd2, d); check("edge_claim_blocked", d, 32'd0);
        do_write(2'd2, 32'd2);
        do_read(2'd2, d); check("edge_reclaim", d, 32'd2);

        // Invalid completes leave state and meip untouched.
        irq[6] = 1'b1;
        idle(4);
        check("inv_meip_before", {31'b0, meip}, 32'd1);
        do_write(2'd2, 32'd0);
        do_write(2'd2, 32'd9);
        do_write(2'd2, 32'd4);
        idle(2);
        check("inv_meip_after", {31'b0, meip}, 32'd1);
        do_read(2'd0, d); check("inv_pending", d, 32'h40);
        do_read(2'd2, d); check("inv_claim", d, 32'd7);
        do_write(2'd2, 32'd2);
        do_write(2'd2, 32'd7);
        irq = '0;
        idle(3);

        // Claim on the same edge as a new rising edge of that source.
        do_reset();
        do_write(2'd1, 32'hFF);
        do_write(2'd3, 32'h02);
        pulse(1);
        idle(2);
        irq[1] = 1'b1;
        idle(2);
        do_read(2'd2, d); check("coinc_claim", d, 32'd2);
        do_read(2'd0, d); check("coinc_pending", d, 32'h02);
        irq = '0;

        // Reset while source 3 is in service and pending again.
        do_reset();
        do_write(2'd1, 32'hFF);
        do_write(2'd3, 32'h08);
        pulse(3);
        idle(2);
        do_read(2'd2, d); check("rst_claim", d, 32'd4);
        pulse(3);
        idle(2);
        do_read(2'd0, d); check("rst_pend_before", d, 32'h08);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_meip", {31'b0, meip}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        do_read(2'd0, d); check("rst_rd_pending", d, 32'd0);
        do_read(2'd1, d); check("rst_rd_enable", d, 32'd0);
        do_read(2'd2, d); check("rst_rd_claim", d, 32'd0);
        do_read(2'd3, d); check("rst_rd_edge", d, 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < NS; i++)
                if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
            rd_en = ($urandom_range(0, 2) == 0);
            wr_en = ($urandom_range(0, 3) == 0);
            addr  = 2'($urandom_range(0, 3));
            wdata = (addr == 2'd2) ? 32'($urandom_range(0, 10)) : $urandom;
            tick();
        end
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
